// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: requester, response and RAM-port signals of the BRAM port arbiter
interface bram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  rq0_valid, rq0_ready, rq0_we, rq0_lock;
    logic [ADDR_WIDTH-1:0] rq0_addr;
    logic [DATA_WIDTH-1:0] rq0_data;
    logic                  rq1_valid, rq1_ready, rq1_we, rq1_lock;
    logic [ADDR_WIDTH-1:0] rq1_addr;
    logic [DATA_WIDTH-1:0] rq1_data;
    logic                  rsp0_valid, rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp0_data, rsp1_data;
    logic                  ram_en, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_di, ram_do;

    modport master (
        output rq0_valid, rq0_we, rq0_lock, rq0_addr, rq0_data,
        output rq1_valid, rq1_we, rq1_lock, rq1_addr, rq1_data,
        input  rq0_ready, rq1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
        input  ram_en, ram_we, ram_addr, ram_di,
        output ram_do
    );

    modport slave (
        input  rq0_valid, rq0_we, rq0_lock, rq0_addr, rq0_data,
        input  rq1_valid, rq1_we, rq1_lock, rq1_addr, rq1_data,
        output rq0_ready, rq1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
        output ram_en, ram_we, ram_addr, ram_di,
        input  ram_do
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: two-requester arbiter/sequencer for one BRAM port with locked bursts and lock timeout.
// BRAM_ARB_STATS_EN adds per-requester saturating grant counters.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int RAM_LATENCY  = 4,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef BRAM_ARB_STATS_EN
    input  logic        stat_clr,
    output logic [31:0] stat_gnt0,
    output logic [31:0] stat_gnt1,
`endif
    bram_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t                state;
    logic                  lastGnt;
    logic [CW-1:0]         idleCnt;
    logic [RAM_LATENCY:0]  tagV, tagId;
    logic                  rdy0, rdy1, acc, accId, accWe, accLock;
    logic [ADDR_WIDTH-1:0] accAddr;
    logic [DATA_WIDTH-1:0] accData;

    // Ready is forced low during reset so every output reads 0 while rst is held
    always_comb begin
        rdy0    = !rst && bus.rq0_valid && (state == LOCK0 || (state == IDLE && (!bus.rq1_valid || lastGnt)));
        rdy1    = !rst && bus.rq1_valid && (state == LOCK1 || (state == IDLE && (!bus.rq0_valid || !lastGnt)));
        acc     = rdy0 || rdy1;
        accId   = rdy1;
        accWe   = accId ? bus.rq1_we   : bus.rq0_we;
        accLock = accId ? bus.rq1_lock : bus.rq0_lock;
        accAddr = accId ? bus.rq1_addr : bus.rq0_addr;
        accData = accId ? bus.rq1_data : bus.rq0_data;
    end

    assign bus.rq0_ready  = rdy0;
    assign bus.rq1_ready  = rdy1;
    assign bus.rsp0_valid = tagV[RAM_LATENCY] && !tagId[RAM_LATENCY];
    assign bus.rsp1_valid = tagV[RAM_LATENCY] && tagId[RAM_LATENCY];
    assign bus.rsp0_data  = bus.rsp0_valid ? bus.ram_do : '0;
    assign bus.rsp1_data  = bus.rsp1_valid ? bus.ram_do : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lastGnt      <= 1'b1;
            idleCnt      <= '0;
            tagV         <= '0;
            tagId        <= '0;
            bus.ram_en   <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_di   <= '0;
        end else begin
            bus.ram_en <= acc;
            bus.ram_we <= acc && accWe;
            tagV       <= {tagV[RAM_LATENCY-1:0], acc && !accWe};
            tagId      <= {tagId[RAM_LATENCY-1:0], accId};
            if (acc) begin
                bus.ram_addr <= accAddr;
                bus.ram_di   <= accData;
                lastGnt      <= accId;
            end
            if (state == IDLE) begin
                idleCnt <= '0;
                if (acc && accLock) state <= accId ? LOCK1 : LOCK0;
            end else if (acc) begin
                idleCnt <= '0;
                if (!accLock) state <= IDLE;
            end else if (idleCnt == CW'(LOCK_TIMEOUT - 1)) begin
                // Holder stayed silent too long: release so the other side is not starved
                idleCnt <= '0;
                state   <= IDLE;
            end else begin
                idleCnt <= idleCnt + 1'b1;
            end
        end
    end

`ifdef BRAM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_gnt0 <= '0;
            stat_gnt1 <= '0;
        end else if (stat_clr) begin
            stat_gnt0 <= '0;
            stat_gnt1 <= '0;
        end else begin
            if (rdy0 && stat_gnt0 != '1) stat_gnt0 <= stat_gnt0 + 32'd1;
            if (rdy1 && stat_gnt1 != '1) stat_gnt1 <= stat_gnt1 + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: vector table plus corner sequences; a scoreboard checks RAM-port commands and read responses.
module tb_bram_port_arbiter;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LAT = 4;
    localparam int TO  = 16;

    typedef struct {
        logic v0, w0, k0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic v1, w1, k1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic r0, r1;
    } vec_t;

    typedef struct { logic id; logic [DW-1:0] data; int cyc; } sb_t;

    logic clk = 0;
    logic rst = 1;
`ifdef BRAM_ARB_STATS_EN
    logic        stat_clr = 0;
    logic [31:0] stat_gnt0, stat_gnt1;
`endif
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    bram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(LAT), .LOCK_TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
`ifdef BRAM_ARB_STATS_EN
        .stat_clr(stat_clr),
        .stat_gnt0(stat_gnt0),
        .stat_gnt1(stat_gnt1),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] initVal(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (b == 8'h12) ? 16'hBEEF : {b, ~b};
    endfunction

    // RAM model: read data appears LAT cycles after the enabled cycle
    logic [DW-1:0] ramMem [256];
    logic [DW-1:0] rdPipe [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ramMem[i] <= initVal(i);
        end else if (bus.ram_en && bus.ram_we) begin
            ramMem[bus.ram_addr] <= bus.ram_di;
        end
        rdPipe[0] <= ramMem[bus.ram_addr];
        for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign bus.ram_do = rdPipe[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard / monitor
    logic [DW-1:0] refMem [256];
    sb_t           sb [$];
    logic          prevAcc, prevWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expDi;

    always @(negedge clk) begin
        logic a0, a1, id, we;
        logic [AW-1:0] ad;
        logic [DW-1:0] dd;
        sb_t e;
        cyc++;
        if (rst) begin
            sb.delete();
            prevAcc = 0;
            prevWe  = 0;
            expAddr = '0;
            expDi   = '0;
            for (int i = 0; i < 256; i++) refMem[i] = initVal(i);
        end else begin
            chk("ram_en", 32'(bus.ram_en), 32'(prevAcc));
            chk("ram_we", 32'(bus.ram_we), 32'(prevWe));
            chk("ram_addr", 32'(bus.ram_addr), 32'(expAddr));
            chk("ram_di", 32'(bus.ram_di), 32'(expDi));
            chk("ready_onehot", 32'(bus.rq0_ready && bus.rq1_ready), 32'd0);
            chk("rsp_onehot", 32'(bus.rsp0_valid && bus.rsp1_valid), 32'd0);
            if (!bus.rsp0_valid) chk("rsp0_data_idle", 32'(bus.rsp0_data), 32'd0);
            if (!bus.rsp1_valid) chk("rsp1_data_idle", 32'(bus.rsp1_data), 32'd0);
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL rsp_unexpected: got rsp0=%0b rsp1=%0b expected none (cycle %0d)",
                             bus.rsp0_valid, bus.rsp1_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(bus.rsp1_valid), 32'(e.id));
                    chk("rsp_data", 32'(e.id ? bus.rsp1_data : bus.rsp0_data), 32'(e.data));
                    chk("rsp_latency", 32'(cyc - e.cyc), 32'(LAT + 1));
                end
            end
            a0 = bus.rq0_valid && bus.rq0_ready;
            a1 = bus.rq1_valid && bus.rq1_ready;
            prevAcc = a0 || a1;
            prevWe  = 0;
            if (a0 || a1) begin
                id = a1;
                we = id ? bus.rq1_we : bus.rq0_we;
                ad = id ? bus.rq1_addr : bus.rq0_addr;
                dd = id ? bus.rq1_data : bus.rq0_data;
                prevWe  = we;
                expAddr = ad;
                expDi   = dd;
                if (we) refMem[ad] = dd;
                else sb.push_back('{id, refMem[ad], cyc});
            end
        end
    end

    function automatic vec_t mk(input logic v0, w0, k0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic v1, w1, k1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic r0, r1);
        vec_t v;
        v = '{v0, w0, k0, a0, d0, v1, w1, k1, a1, d1, r0, r1};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.rq0_valid = v.v0; bus.rq0_we = v.w0; bus.rq0_lock = v.k0; bus.rq0_addr = v.a0; bus.rq0_data = v.d0;
        bus.rq1_valid = v.v1; bus.rq1_we = v.w1; bus.rq1_lock = v.k1; bus.rq1_addr = v.a1; bus.rq1_data = v.d1;
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(posedge clk);
        #1 drive(v);
        @(negedge clk);
        chk($sformatf("%s ready0", nm), 32'(bus.rq0_ready), 32'(v.r0));
        chk($sformatf("%s ready1", nm), 32'(bus.rq1_ready), 32'(v.r1));
    endtask

    task automatic chkQuiet(input string nm);
        chk($sformatf("%s rq0_ready", nm), 32'(bus.rq0_ready), 32'd0);
        chk($sformatf("%s rq1_ready", nm), 32'(bus.rq1_ready), 32'd0);
        chk($sformatf("%s ram_en", nm), 32'(bus.ram_en), 32'd0);
        chk($sformatf("%s ram_we", nm), 32'(bus.ram_we), 32'd0);
        chk($sformatf("%s ram_addr", nm), 32'(bus.ram_addr), 32'd0);
        chk($sformatf("%s ram_di", nm), 32'(bus.ram_di), 32'd0);
        chk($sformatf("%s rsp0_valid", nm), 32'(bus.rsp0_valid), 32'd0);
        chk($sformatf("%s rsp1_valid", nm), 32'(bus.rsp1_valid), 32'd0);
        chk($sformatf("%s rsp0_data", nm), 32'(bus.rsp0_data), 32'd0);
        chk($sformatf("%s rsp1_data", nm), 32'(bus.rsp1_data), 32'd0);
    endtask

    vec_t tbl [17];
    vec_t idle;
    vec_t both;

    initial begin
        idle = mk(0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0, 0,0);
        both = mk(1,0,0,8'h12,16'h0, 1,0,0,8'h20,16'h0, 0,0);
        tbl[0]  = idle;
        tbl[1]  = mk(1,0,0,8'h12,16'h0,    0,0,0,8'h00,16'h0,    1,0);
        tbl[2]  = idle;
        tbl[3]  = mk(0,0,0,8'h00,16'h0,    1,0,0,8'h20,16'h0,    0,1);
        tbl[4]  = mk(1,0,0,8'h01,16'h0,    1,0,0,8'h02,16'h0,    1,0);
        tbl[5]  = mk(1,0,0,8'h03,16'h0,    1,0,0,8'h04,16'h0,    0,1);
        tbl[6]  = mk(1,0,0,8'h05,16'h0,    1,0,0,8'h06,16'h0,    1,0);
        tbl[7]  = mk(1,0,0,8'h07,16'h0,    1,0,0,8'h08,16'h0,    0,1);
        tbl[8]  = mk(1,1,0,8'h30,16'h1234, 0,0,0,8'h00,16'h0,    1,0);
        tbl[9]  = mk(1,0,0,8'h30,16'h0,    1,1,1,8'h40,16'hA001, 0,1);
        tbl[10] = mk(1,0,0,8'h30,16'h0,    1,1,1,8'h41,16'hA002, 0,1);
        tbl[11] = mk(1,0,0,8'h30,16'h0,    1,1,1,8'h42,16'hA003, 0,1);
        tbl[12] = mk(1,0,0,8'h30,16'h0,    1,1,0,8'h43,16'hA004, 0,1);
        tbl[13] = mk(1,0,0,8'h40,16'h0,    0,0,0,8'h00,16'h0,    1,0);
        tbl[14] = mk(1,0,1,8'h30,16'h0,    1,0,0,8'h41,16'h0,    0,1);
        tbl[15] = mk(0,0,0,8'h00,16'h0,    1,0,0,8'h42,16'h0,    0,1);
        tbl[16] = mk(1,0,0,8'h43,16'h0,    1,0,0,8'h30,16'h0,    1,0);

        drive(both);
        @(negedge clk);
        chkQuiet("reset_state");
        @(posedge clk);
        #1 rst = 0;
        drive(idle);

        for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Lock timeout, with a mid-lock acceptance that must restart the idle count
        apply(mk(1,0,1,8'h50,16'h0, 0,0,0,8'h00,16'h0, 1,0), "to_lock");
        for (int k = 1; k <= 8; k++) apply(mk(0,0,0,8'h00,16'h0, 1,0,0,8'h60,16'h0, 0,0), $sformatf("to_pre%0d", k));
        apply(mk(1,0,1,8'h51,16'h0, 1,0,0,8'h60,16'h0, 1,0), "to_relock");
        for (int k = 1; k <= TO + 1; k++)
            apply(mk(0,0,0,8'h00,16'h0, 1,0,0,8'h60,16'h0, 0,(k == TO + 1)), $sformatf("to_wait%0d", k));
        apply(idle, "to_after");

        // Reset with three reads in flight
        for (int k = 0; k < 3; k++) apply(mk(1,0,0,8'(8'h70 + k),16'h0, 0,0,0,8'h00,16'h0, 1,0), $sformatf("rr_rd%0d", k));
        @(posedge clk);
        #1 rst = 1;
        drive(both);
        @(negedge clk);
        chkQuiet("mid_reset");
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("post_rst ready0", 32'(bus.rq0_ready), 32'd1);
        chk("post_rst ready1", 32'(bus.rq1_ready), 32'd0);
        apply(mk(1,0,0,8'h12,16'h0, 1,0,0,8'h20,16'h0, 0,1), "post_rst2");
        apply(mk(1,0,0,8'h12,16'h0, 1,0,0,8'h20,16'h0, 1,0), "post_rst3");
        apply(idle, "post_rst_idle");

`ifdef BRAM_ARB_STATS_EN
        @(posedge clk);
        #1 stat_clr = 1;
        @(posedge clk);
        #1 stat_clr = 0;
        for (int k = 0; k < 5; k++) apply(mk(1,0,0,8'(k),16'h0, 0,0,0,8'h00,16'h0, 1,0), "st_rq0");
        for (int k = 0; k < 3; k++) apply(mk(0,0,0,8'h00,16'h0, 1,0,0,8'(k),16'h0, 0,1), "st_rq1");
        apply(idle, "st_idle");
        chk("stat_gnt0", stat_gnt0, 32'd5);
        chk("stat_gnt1", stat_gnt1, 32'd3);
        @(posedge clk);
        #1 stat_clr = 1;
        drive(mk(1,0,0,8'h09,16'h0, 0,0,0,8'h00,16'h0, 1,0));
        @(negedge clk);
        chk("st_clr ready0", 32'(bus.rq0_ready), 32'd1);
        @(posedge clk);
        #1 stat_clr = 0;
        drive(idle);
        @(negedge clk);
        chk("stat_gnt0_clr", stat_gnt0, 32'd0);
        chk("stat_gnt1_clr", stat_gnt1, 32'd0);
`endif

        repeat (LAT + 3) @(negedge clk);
        chk("drain_pending", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Two-requester arbiter and sequencer for one port of a dual-port block RAM (wishbone bus side vs. DSP fabric side).
- Issues at most one RAM access per cycle and drives the port's enable, write-enable, address and data.
- Tracks the RAM's fixed read latency and routes read data back to the requester that issued the read.
- Supports locked bursts, with a timeout so a stalled lock holder cannot starve the other side.

Parameters:
- ADDR_WIDTH, 8, RAM port address width.
- DATA_WIDTH, 16, RAM port data width.
- RAM_LATENCY, 4, cycles from ram_en to valid ram_do (RAM output register count + 1); must be >= 1.
- LOCK_TIMEOUT, 16, idle cycles a lock holder may go without issuing a request before the lock is dropped; must be >= 1.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- rq0_valid / rq1_valid  in  1  request present.
- rq0_ready / rq1_ready  out  1  request accepted this cycle; combinational from arbiter state and valids.
- rq0_we / rq1_we  in  1  1 = write, 0 = read.
- rq0_lock / rq1_lock  in  1  retain the grant after this access.
- rq0_addr / rq1_addr  in  ADDR_WIDTH  access address.
- rq0_data / rq1_data  in  DATA_WIDTH  write data.
- rsp0_valid / rsp1_valid  out  1  read data valid, one-cycle pulse per read.
- rsp0_data / rsp1_data  out  DATA_WIDTH  read data.
- ram_en  out  1  RAM port enable, registered.
- ram_we  out  1  RAM write enable, registered.
- ram_addr  out  ADDR_WIDTH  registered address.
- ram_di  out  DATA_WIDTH  registered write data.
- ram_do  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset: all outputs 0; state IDLE; last_gnt = 1 (so requester 0 wins the first contention); tag pipeline cleared; timeout counter cleared.
- A request is accepted in cycle t when rqN_valid && rqN_ready. At most one ready is high per cycle.
- At the edge ending cycle t: ram_en=1, and ram_we/ram_addr/ram_di take the accepted request's values. With no acceptance, ram_en=0 and ram_we=0; addr and data hold their previous values.
- Read response timing: rspN_valid pulses exactly RAM_LATENCY+1 cycles after the acceptance cycle. rspN_data equals ram_do in that cycle; it is 0 when rspN_valid=0.
- Tag pipeline: RAM_LATENCY+1 stages carrying {valid, id}. Writes insert valid=0 and produce no response.
- Back-to-back reads from either requester are accepted every cycle. Responses return in issue order.
- States:
  - IDLE:
    - Both valid: grant the requester != last_gnt.
    - One valid: grant it.
    - After a grant, last_gnt <= granted id.
    - If the granted request has lock=1, go to LOCKn.
  - LOCKn:
    - Only requester n may be ready; the other's ready=0.
    - Accepting n with lock=0 returns to IDLE.
    - The timeout counter resets on every acceptance from n and increments on each cycle with rqN_valid=0.
    - When the counter reaches LOCK_TIMEOUT, go to IDLE and clear the counter. The other requester may be granted in the first IDLE cycle.
- Lock asserted by the non-granted requester has no effect.
- Asynchronous reset mid-operation: in-flight reads are discarded and no rsp_valid is produced for them. A lock in progress is dropped.
- RAM read/write collision semantics belong to the RAM; the arbiter does not forward data.

Optional Feature:
- Macro BRAM_ARB_STATS_EN.
- Defined:
  - Adds input stat_clr (1 bit) and outputs stat_gnt0 / stat_gnt1 (32 bits each).
  - Each counter increments on acceptance for its requester and saturates at 0xFFFFFFFF.
  - Counters are cleared synchronously by stat_clr (clear wins over increment) and asynchronously by rst.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single read: rq0 read addr 0x12 accepted at cycle 10, RAM model returns 0xBEEF → ram_en=1 with ram_addr=0x12 in cycle 11; rsp0_valid=1 with data 0xBEEF in cycle 15 only; rsp1_valid stays 0.
- Contention: both valid with reads every cycle, no lock → grants alternate 0,1,0,1 starting with 0 after reset; responses return in the same alternating order with the correct ids.
- Burst lock: rq1 issues 4 writes with lock=1,1,1,0 while rq0_valid is held high → rq0_ready=0 throughout the burst; rq0 is granted in the cycle after rq1's last write.
- Lock timeout: rq0 locks, then drops valid for 16 cycles while rq1_valid=1 → rq1_ready asserts on the 17th cycle after rq0's last acceptance.
- Reset mid-read: 3 reads in flight, rst pulsed for 1 cycle → no rsp_valid for those reads; all outputs 0 during reset; the next contention grants requester 0 first.
- With BRAM_ARB_STATS_EN defined: 5 accepts on rq0 and 3 on rq1 → stat_gnt0=5, stat_gnt1=3. stat_clr asserted alongside an accept → both counters read 0 the next cycle.
